// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the two-requester memory arbiter:
//   - default address/data widths (32 words of 8 bits)
//   - the arbiter FSM state encoding
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      READ_WAIT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin grant, purely combinational.
// Ports:
//   valid0, valid1 : requests
//   last_grant     : id of the requester granted last (0 or 1)
//   grant[1:0]     : one-hot grant, all-zero when nobody requests
// A lone request always wins; on a tie the requester not granted last wins.
module rr_arbiter2 (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       last_grant,
   output logic [1:0] grant
);

   assign grant[0] = valid0 & (~valid1 | last_grant);
   assign grant[1] = valid1 & (~valid0 | ~last_grant);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one synchronous data memory between two requesters.
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata  : command from requester N (N = 0, 1)
//   reqN_ready                   : command taken at this edge when valid is also high
//   reqN_rvalid/rdata            : one-cycle read-return pulse and held read data
//   signal_memread/memwrite      : registered one-cycle memory strobes
//   mem_address, data_to_write   : registered memory address / write data
//   data_out                     : memory read data, valid one edge after signal_memread
// Handshake: a command transfers on a rising edge where valid and ready are both
// high. Ready is only offered in IDLE, so at most one command is in flight; the
// requester must hold its fields stable until that edge.
// Command timeline (accept edge ends cycle 0): strobe in cycle 1 (ISSUE); reads
// then spend cycle 2 in READ_WAIT and pulse rvalid in cycle 3, which is also an
// IDLE cycle and may accept the next command.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_rvalid,
   output logic [DATA_W-1:0] req0_rdata,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_rvalid,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              signal_memread,
   output logic              signal_memwrite,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] data_to_write,
   input  logic [DATA_W-1:0] data_out
);

   arb_state_t        state;
   arb_state_t        state_next;
   logic              last_grant;
   logic              cur_id;
   logic              cur_write;
   logic [1:0]        grant;
   logic              accept;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arbiter2 u_rr (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // Ready is gated by reset so no command is ever taken on a reset edge.
   assign req0_ready = (state == IDLE) && !reset && grant[0];
   assign req1_ready = (state == IDLE) && !reset && grant[1];
   assign accept     = req0_ready | req1_ready;

   // Fields of the winning requester.
   always_comb begin
      sel_write = req0_write;
      sel_addr  = req0_addr;
      sel_wdata = req0_wdata;
      if (grant[1]) begin
         sel_write = req1_write;
         sel_addr  = req1_addr;
         sel_wdata = req1_wdata;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (accept) state_next = ISSUE;
         ISSUE:     state_next = cur_write ? IDLE : READ_WAIT;
         READ_WAIT: state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         signal_memread  <= 1'b0;
         signal_memwrite <= 1'b0;
         req0_rvalid     <= 1'b0;
         req1_rvalid     <= 1'b0;
         req0_rdata      <= '0;
         req1_rdata      <= '0;
         mem_address     <= '0;
         data_to_write   <= '0;
         last_grant      <= 1'b1;   // req0 wins the first tie
         cur_id          <= 1'b0;
         cur_write       <= 1'b0;
      end else begin
         state           <= state_next;
         signal_memread  <= 1'b0;
         signal_memwrite <= 1'b0;
         req0_rvalid     <= 1'b0;
         req1_rvalid     <= 1'b0;
         if (accept) begin
            last_grant      <= grant[1];
            cur_id          <= grant[1];
            cur_write       <= sel_write;
            mem_address     <= sel_addr;
            data_to_write   <= sel_wdata;
            signal_memwrite <= sel_write;
            signal_memread  <= ~sel_write;
         end
         // data_out was registered by the memory at the end of ISSUE.
         if (state == READ_WAIT) begin
            if (cur_id) begin
               req1_rdata  <= data_out;
               req1_rvalid <= 1'b1;
            end else begin
               req0_rdata  <= data_out;
               req0_rvalid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Bench for mem_arbiter with a behavioural memory and a cycle-counting
// reference model: each accepted command books its strobe cycle, its
// read-return cycle and the cycle the arbiter is free again.
module tb_mem_arbiter;

   localparam int AW = 5;
   localparam int DW = 8;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic          req0_valid = 0, req0_write = 0;
   logic [AW-1:0] req0_addr = '0;
   logic [DW-1:0] req0_wdata = '0;
   logic          req0_ready, req0_rvalid;
   logic [DW-1:0] req0_rdata;
   logic          req1_valid = 0, req1_write = 0;
   logic [AW-1:0] req1_addr = '0;
   logic [DW-1:0] req1_wdata = '0;
   logic          req1_ready, req1_rvalid;
   logic [DW-1:0] req1_rdata;
   logic          signal_memread, signal_memwrite;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] data_to_write;
   logic [DW-1:0] data_out = '0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
      .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
      .req1_rdata(req1_rdata),
      .signal_memread(signal_memread), .signal_memwrite(signal_memwrite),
      .mem_address(mem_address), .data_to_write(data_to_write), .data_out(data_out)
   );

   // Synchronous data memory (not reset).
   logic [DW-1:0] mem [0:31];
   always @(posedge clock) begin
      if (signal_memwrite) mem[mem_address] <= data_to_write;
      if (signal_memread)  data_out <= mem[mem_address];
   end

   // ---------------- reference model ----------------
   logic [DW-1:0] mem_model [0:31];
   logic [DW-1:0] exp_q [$];          // read data awaiting return, in order
   int            cyc, next_free, strobe_cyc, rv_cyc, last_acc_cyc;
   logic          last_id, strobe_wr, rv_id;
   logic [AW-1:0] exp_maddr;
   logic [DW-1:0] exp_wdata;
   logic [DW-1:0] exp_rdata [2];
   logic          acc0, acc1;
   int            act_ids [$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      last_id      = 1'b1;
      strobe_cyc   = -1;
      rv_cyc       = -1;
      exp_maddr    = '0;
      exp_wdata    = '0;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      exp_q.delete();
      next_free    = cyc + 1;
   endtask

   // One clock cycle: inputs are already driven; check mid-cycle, then advance.
   task automatic step();
      logic free, er0, er1, id, wr;
      logic [AW-1:0] ad;
      logic [DW-1:0] wd;
      @(negedge clock);
      free = (cyc >= next_free) && !reset;
      er0  = free && req0_valid && (!req1_valid || last_id == 1'b1);
      er1  = free && req1_valid && (!req0_valid || last_id == 1'b0);
      if (cyc == rv_cyc) begin
         if (exp_q.size() > 0) exp_rdata[rv_id] = exp_q.pop_front();
      end
      check("ready0", req0_ready, er0);
      check("ready1", req1_ready, er1);
      check("memread", signal_memread, (cyc == strobe_cyc) && !strobe_wr);
      check("memwrite", signal_memwrite, (cyc == strobe_cyc) && strobe_wr);
      check("strobe_excl", signal_memread & signal_memwrite, 1'b0);
      check("mem_address", mem_address, exp_maddr);
      check("data_to_write", data_to_write, exp_wdata);
      check("rvalid0", req0_rvalid, (cyc == rv_cyc) && rv_id == 1'b0);
      check("rvalid1", req1_rvalid, (cyc == rv_cyc) && rv_id == 1'b1);
      check("rdata0", req0_rdata, exp_rdata[0]);
      check("rdata1", req1_rdata, exp_rdata[1]);
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (acc0) begin act_ids.push_back(0); last_acc_cyc = cyc; end
      if (acc1) begin act_ids.push_back(1); last_acc_cyc = cyc; end
      if (reset) begin
         model_reset();
      end else if (er0 || er1) begin
         id = er1;
         wr = id ? req1_write : req0_write;
         ad = id ? req1_addr  : req0_addr;
         wd = id ? req1_wdata : req0_wdata;
         last_id    = id;
         strobe_cyc = cyc + 1;
         strobe_wr  = wr;
         exp_maddr  = ad;
         exp_wdata  = wd;
         if (wr) begin
            mem_model[ad] = wd;
            next_free = cyc + 2;
         end else begin
            exp_q.push_back(mem_model[ad]);
            rv_cyc    = cyc + 3;
            rv_id     = id;
            next_free = cyc + 3;
         end
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_req(input int id, input logic v, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (id == 0) begin
         req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
      end
   endtask

   // Present one command and hold it until accepted (bounded), then drop valid.
   task automatic issue(input int id, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      int n;
      logic got;
      drive_req(id, 1'b1, w, a, d);
      got = 1'b0;
      n = 0;
      while (!got && n < 20) begin
         step();
         got = (id == 0) ? acc0 : acc1;
         n++;
      end
      check("accept_timeout", got, 1'b1);
      drive_req(id, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic idle_cycles(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int c1, c2, n_acc, budget, base;
   logic          pend [2];
   logic          pw [2];
   logic [AW-1:0] pa [2];
   logic [DW-1:0] pd [2];

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i]       = DW'($urandom);
         mem_model[i] = mem[i];
      end
      cyc = 0;
      last_acc_cyc = 0;
      // Reset with a request already pending: ready must stay low.
      req0_valid = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("rst_ready0", req0_ready, 1'b0);
      check("rst_memread", signal_memread, 1'b0);
      check("rst_memwrite", signal_memwrite, 1'b0);
      check("rst_rvalid0", req0_rvalid, 1'b0);
      check("rst_rvalid1", req1_rvalid, 1'b0);
      check("rst_rdata0", req0_rdata, '0);
      check("rst_rdata1", req1_rdata, '0);
      check("rst_addr", mem_address, '0);
      check("rst_wdata", data_to_write, '0);
      req0_valid = 1'b0;
      reset = 1'b0;
      model_reset();
      next_free = 0;

      // Write then read back through requester 0.
      issue(0, 1'b1, 5'd5, 8'hA5);
      check("wr_strobe", signal_memwrite, 1'b1);
      check("wr_addr", mem_address, 5'd5);
      idle_cycles(1);
      issue(0, 1'b0, 5'd5, 8'h00);
      idle_cycles(2);
      check("rd_a5", req0_rvalid, 1'b1);
      check("rd_a5_data", req0_rdata, 8'hA5);
      idle_cycles(1);

      // Simultaneous reads after reset: req0 first, then req1.
      do_reset();
      act_ids.delete();
      drive_req(0, 1'b1, 1'b0, 5'd1, '0);
      drive_req(1, 1'b1, 1'b0, 5'd2, '0);
      budget = 0;
      while (act_ids.size() < 2 && budget < 20) begin
         step();
         if (acc0) drive_req(0, 1'b0, 1'b0, '0, '0);
         if (acc1) drive_req(1, 1'b0, 1'b0, '0, '0);
         budget++;
      end
      check("tie_count", act_ids.size(), 2);
      if (act_ids.size() == 2) begin
         check("tie_first", act_ids[0], 0);
         check("tie_second", act_ids[1], 1);
      end
      idle_cycles(4);

      // Both valid continuously for six commands: grants alternate.
      act_ids.delete();
      n_acc = 0;
      drive_req(0, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
      drive_req(1, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
      budget = 0;
      while (n_acc < 6 && budget < 60) begin
         step();
         if (acc0 || acc1) n_acc++;
         if (acc0) drive_req(0, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
         if (acc1) drive_req(1, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
         budget++;
      end
      drive_req(0, 1'b0, 1'b0, '0, '0);
      drive_req(1, 1'b0, 1'b0, '0, '0);
      check("alt_count", act_ids.size(), 6);
      for (int k = 0; k < act_ids.size() && k < 6; k++)
         check($sformatf("alt_grant%0d", k), act_ids[k], k % 2);
      idle_cycles(4);

      // Reset during READ_WAIT of a req1 read: no return afterwards.
      issue(1, 1'b0, 5'd7, '0);   // now in ISSUE
      step();                      // ISSUE cycle
      do_reset();                  // reset during READ_WAIT
      check("rst_rw_rvalid1", req1_rvalid, 1'b0);
      check("rst_rw_rdata1", req1_rdata, '0);
      check("rst_rw_memread", signal_memread, 1'b0);
      idle_cycles(4);

      // Back-to-back writes from req1 to the two end addresses.
      issue(1, 1'b1, 5'd0, 8'h3C);
      c1 = last_acc_cyc;
      issue(1, 1'b1, 5'd31, 8'hC3);
      c2 = last_acc_cyc;
      check("b2b_gap", c2 - c1, 2);
      idle_cycles(1);
      issue(1, 1'b0, 5'd0, '0);
      idle_cycles(2);
      check("rb_addr0", req1_rdata, 8'h3C);
      issue(1, 1'b0, 5'd31, '0);
      idle_cycles(2);
      check("rb_addr31", req1_rdata, 8'hC3);
      idle_cycles(1);

      // req0 pulses valid while req1 is in ISSUE, then withdraws.
      act_ids.delete();
      issue(1, 1'b1, 5'd10, 8'h5A);
      drive_req(0, 1'b1, 1'b1, 5'd3, 8'hEE);
      step();
      drive_req(0, 1'b0, 1'b0, '0, '0);
      idle_cycles(3);
      check("drop_accepts", act_ids.size(), 1);

      // Random traffic with withdrawals and occasional reset.
      pend[0] = 0; pend[1] = 0;
      for (int t = 0; t < 400; t++) begin
         for (int id = 0; id < 2; id++) begin
            if (!pend[id] && $urandom_range(0, 2) == 0) begin
               pend[id] = 1; pw[id] = 1'($urandom);
               pa[id] = AW'($urandom); pd[id] = DW'($urandom);
            end else if (pend[id] && $urandom_range(0, 15) == 0) begin
               pend[id] = 0;
            end
            drive_req(id, pend[id], pw[id], pa[id], pd[id]);
         end
         reset = ($urandom_range(0, 99) == 0);
         step();
         if (acc0) pend[0] = 0;
         if (acc1) pend[1] = 0;
      end
      reset = 1'b0;
      drive_req(0, 1'b0, 1'b0, '0, '0);
      drive_req(1, 1'b0, 1'b0, '0, '0);
      idle_cycles(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
